hilo_unit: RTL and testbench

HI/LO architectural register pair and multi-cycle sequencer downstream of the multiply/divide datapath. The block captures the datapath's `hi`/`lo` results when an operation issues and holds `busy` for a fixed latency per operation class: `MUL_LAT` for multiplies, `DIV_LAT` for divides. It then commits the results to HI/LO and serves `mfhi`/`mflo` reads. While an operation is in flight it raises `stall` to the pipeline for any HI/LO access or a new issue.

---
 rtl/hilo_unit.sv | 109 ++++++++++
 tb/tb_hilo_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_unit.sv
// HI/LO architectural registers with a fixed-latency sequencer for mult/div results.
// Results are captured at issue and committed after the op-class latency.
module hilo_unit #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        md_start,
  input  logic [3:0]  md_op,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  input  logic [1:0]  mt_op,
  input  logic [31:0] mt_data,
  input  logic [1:0]  mf_op,
  input  logic        flush,
  output logic [31:0] mf_data,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        is_div;

  // Only opcodes 0/1 are divides; every other code, legal or not, runs as a multiply.
  assign is_div = (md_op == 4'd0) || (md_op == 4'd1);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      IDLE: begin
        if (!flush) begin
          if (md_start) begin
            pend_hi_d = md_hi;
            pend_lo_d = md_lo;
            cnt_d     = is_div ? DIV_CNT : MUL_CNT;
            state_d   = BUSY;
          end else begin
            if (mt_op[0]) hi_d = mt_data;
            if (mt_op[1]) lo_d = mt_data;
          end
        end
      end
      BUSY: begin
        // Flush beats commit, even on the final cycle.
        if (flush) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy    = (state_q == BUSY);
  assign stall   = busy & (md_start | (mt_op != 2'b00) | (mf_op != 2'b00));
  assign mf_data = (mf_op == 2'b10) ? lo_q : hi_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit at default latencies (MUL_LAT=4, DIV_LAT=12).
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        md_start;
  logic [3:0]  md_op;
  logic [31:0] md_hi, md_lo;
  logic [1:0]  mt_op;
  logic [31:0] mt_data;
  logic [1:0]  mf_op;
  logic        flush;
  logic [31:0] mf_data;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  hilo_unit #(.MUL_LAT(4), .DIV_LAT(12)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_start (md_start),
    .md_op    (md_op),
    .md_hi    (md_hi),
    .md_lo    (md_lo),
    .mt_op    (mt_op),
    .mt_data  (mt_data),
    .mf_op    (mf_op),
    .flush    (flush),
    .mf_data  (mf_data),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] h, input logic [31:0] l);
    md_start = 1'b1; md_op = op; md_hi = h; md_lo = l;
    tick();
    md_start = 1'b0; md_hi = 32'hBAD0BAD0; md_lo = 32'hBAD1BAD1;
  endtask

  initial begin
    rst_n = 1'b0; md_start = 1'b0; md_op = 4'd0; md_hi = 32'd0; md_lo = 32'd0;
    mt_op = 2'b00; mt_data = 32'd0; mf_op = 2'b00; flush = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_mf", mf_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Multiply: busy for 4 cycles, commit on the 4th edge
    issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFE);
    for (int i = 0; i < 3; i++) begin
      check("mul_busy", 32'(busy), 32'd1);
      check("mul_hi_hold", hi, 32'd0);
      tick();
    end
    check("mul_busy_last", 32'(busy), 32'd1);
    check("mul_lo_hold", lo, 32'd0);
    tick();
    check("mul_busy_done", 32'(busy), 32'd0);
    check("mul_hi", hi, 32'hFFFFFFFF);
    check("mul_lo", lo, 32'hFFFFFFFE);

    // Divide: 12 cycles, mflo stalls while busy
    issue(4'd1, 32'd3, 32'd14);
    mf_op = 2'b10; #1;
    check("div_mf_stall", 32'(stall), 32'd1);
    check("div_mf_old_lo", mf_data, 32'hFFFFFFFE);
    mf_op = 2'b00;
    for (int i = 0; i < 11; i++) tick();
    check("div_busy_last", 32'(busy), 32'd1);
    check("div_hi_hold", hi, 32'hFFFFFFFF);
    tick();
    check("div_busy_done", 32'(busy), 32'd0);
    mf_op = 2'b10; #1;
    check("div_mflo", mf_data, 32'd14);
    check("div_nostall", 32'(stall), 32'd0);
    mf_op = 2'b01; #1;
    check("div_mfhi", mf_data, 32'd3);
    mf_op = 2'b11; #1;
    check("mf_illegal_hi", mf_data, 32'd3);
    mf_op = 2'b00;

    // mthi/mtlo
    mt_op = 2'b11; mt_data = 32'h12345678;
    tick();
    mt_op = 2'b00;
    check("mt_hi", hi, 32'h12345678);
    check("mt_lo", lo, 32'h12345678);
    mt_op = 2'b01; mt_data = 32'h00000055;
    tick();
    mt_op = 2'b00;
    check("mthi_only_hi", hi, 32'h00000055);
    check("mthi_only_lo", lo, 32'h12345678);
    issue(4'd3, 32'hAAAA0001, 32'hAAAA0002);
    mt_op = 2'b11; mt_data = 32'hDEADBEEF; #1;
    check("mt_busy_stall", 32'(stall), 32'd1);
    tick();
    check("mt_busy_nowrite", hi, 32'h00000055);
    mt_op = 2'b00;
    tick(); tick();
    check("mt_mul_commit_hold", lo, 32'h12345678);
    tick();
    check("mt_mul_commit_hi", hi, 32'hAAAA0001);
    check("mt_mul_commit_lo", lo, 32'hAAAA0002);

    // Flush on busy cycle 2
    issue(4'd2, 32'h11111111, 32'h22222222);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush2_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("flush2_hi", hi, 32'hAAAA0001);
    check("flush2_lo", lo, 32'hAAAA0002);

    // Flush on final cycle
    issue(4'd2, 32'h33333333, 32'h44444444);
    tick(); tick(); tick();
    check("flushL_busy_pre", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flushL_busy", 32'(busy), 32'd0);
    check("flushL_hi", hi, 32'hAAAA0001);
    check("flushL_lo", lo, 32'hAAAA0002);

    // Flush in idle suppresses md_start and mt_op
    flush = 1'b1; md_start = 1'b1; md_op = 4'd2; mt_op = 2'b11; mt_data = 32'h99999999;
    tick();
    flush = 1'b0; md_start = 1'b0; mt_op = 2'b00;
    check("flushI_busy", 32'(busy), 32'd0);
    check("flushI_hi", hi, 32'hAAAA0001);

    // Async reset mid-divide
    issue(4'd0, 32'h55555555, 32'h66666666);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check("arst_no_commit_hi", hi, 32'd0);
    check("arst_no_commit_busy", 32'(busy), 32'd0);

    // Back-to-back: second start held, illegal op runs as multiply
    issue(4'd2, 32'd1, 32'd2);
    md_start = 1'b1; md_op = 4'hF; md_hi = 32'd5; md_lo = 32'd6; #1;
    for (int i = 0; i < 3; i++) begin
      check("b2b_stall", 32'(stall), 32'd1);
      tick();
    end
    check("b2b_stall_last", 32'(stall), 32'd1);
    tick();
    check("b2b_first_hi", hi, 32'd1);
    check("b2b_first_lo", lo, 32'd2);
    check("b2b_idle", 32'(busy), 32'd0);
    check("b2b_unstall", 32'(stall), 32'd0);
    tick();
    md_start = 1'b0;
    check("b2b_second_busy", 32'(busy), 32'd1);
    check("b2b_second_hold", hi, 32'd1);
    tick(); tick(); tick();
    check("b2b_second_busy_last", 32'(busy), 32'd1);
    tick();
    check("b2b_second_hi", hi, 32'd5);
    check("b2b_second_lo", lo, 32'd6);
    check("b2b_second_done", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
